bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
Countdown counterpart to the team's stopwatch. Holds a preset time SS.hh as 4 BCD digits (tens, ones, tenths, hundredths) and decrements it at 100 Hz until it reaches 00.00. It then raises a one-cycle done pulse and an expired level. Its count_bcd output drives the same seven_segment_decoder instances used by the stopwatch top, on HEX5..HEX2.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz.
TICK_HZ, 100, decrement rate in Hz. DIV = CLK_HZ/TICK_HZ must be an integer >= 2.

Ports:
CLOCK_50  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
load  input  1  one-cycle strobe; loads load_value into the count.
load_value  input  16  preset BCD: [15:12] tens s, [11:8] ones s, [7:4] tenths, [3:0] hundredths.
start_stop  input  1  one-cycle strobe (already debounced and edge-detected upstream); toggles run/pause.
count_bcd  output  16  current count, same digit layout as load_value.
running  output  1  high while in RUN.
expired  output  1  high while in EXPIRED.
done  output  1  one-cycle pulse on the cycle the count reaches 0000.

Behaviour:
- Reset: count_bcd=0000, state IDLE, prescaler=0, running=0, expired=0, done=0.
- States:
  - IDLE: loaded or reset, not counting.
  - RUN: counting.
  - PAUSED: stopped mid-count.
  - EXPIRED: count hit zero.
- Priority each cycle: reset > load > start_stop > tick.
- load, from any state:
  - count <= load_value, with any digit >9 clamped to 9.
  - state <= IDLE; prescaler <= 0; expired <= 0.
  - A coincident start_stop is ignored.
- start_stop:
  - IDLE or PAUSED with count != 0000 -> RUN.
  - IDLE or PAUSED with count == 0000 -> ignored.
  - RUN -> PAUSED.
  - EXPIRED -> ignored.
- Prescaler:
  - Counts 0..DIV-1 only in RUN.
  - Cleared to 0 on entering PAUSED or IDLE, so a resumed count always waits a full DIV cycles.
  - tick = 1 when the prescaler == DIV-1 in RUN; the prescaler wraps to 0 on that cycle.
- Decrement on tick, ripple-borrow from the hundredths digit upward:
  - A digit equal to 0 becomes 9 and borrows into the next digit.
  - Otherwise the digit decrements by 1 and the borrow chain stops.
  - The tens digit ranges 0-9, so the full range is 99.99 down to 00.00.
- Zero detect:
  - On the tick where the next count == 0000: count <= 0000, state <= EXPIRED.
  - done=1 for exactly the following cycle. expired=1 from that cycle until load or reset.
  - The count never wraps below 0000.
- Latency:
  - count_bcd updates on the clock edge after the tick.
  - running changes on the clock edge after start_stop.
  - done and expired are registered; no combinational input-to-output paths.
- Reset mid-RUN: all state cleared as above, and done is not asserted.

Decomposition:
- Package timer_pkg holds:
  - state enum (IDLE, RUN, PAUSED, EXPIRED), 2 bits.
  - BCD digit width constant = 4.
  - DIV derivation function and prescaler width = clog2(DIV).
- Sub-module bcd_down_digit:
  - Inputs: 4-bit digit, borrow_in, load, load_digit.
  - Outputs: next digit, borrow_out.
  - Instantiated 4 times in a chain.

Test Plan (CLK_HZ=1000, TICK_HZ=100, so DIV=10):
- reset, then load 16'h0102 and one start_stop -> running=1. count becomes 0101 after 10 cycles, 0100 after 20, then 0099, then 0098 (borrow across two digits).
- load 16'h0003, start -> count steps 0002, 0001, 0000. done is high for exactly 1 cycle, then expired=1, running=0. A further start_stop leaves the state EXPIRED.
- load 16'h0050, start, start_stop after 15 cycles (count=0049) -> PAUSED, count holds 0049 for 100 cycles. Restart -> 0048 appears exactly 10 cycles later.
- load 16'h0000 then start_stop -> stays IDLE, running=0, done never asserts.
- load 16'hAF9C -> count=9999 (clamped). Start -> next count 9998.
- While RUN at 0042, assert load=1 (value 16'h1000) and start_stop=1 together -> count=1000, IDLE, running=0. Separately, reset asserted mid-RUN -> count=0000 and all outputs 0 on the next edge.

Source files
------------

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam int unsigned DIGIT_W = 4;

  function automatic int unsigned calc_div(int unsigned clk_hz, int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int unsigned presc_width(int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle between a timer and whatever sequences it.
interface bcd_countdown_timer_if;
  import timer_pkg::*;

  logic                     load;
  logic [4*DIGIT_W-1:0]     load_value;
  logic                     start_stop;
  logic [4*DIGIT_W-1:0]     count_bcd;
  logic                     running;
  logic                     expired;
  logic                     done;

  modport master (
    output load, load_value, start_stop,
    input  count_bcd, running, expired, done
  );

  modport slave (
    input  load, load_value, start_stop,
    output count_bcd, running, expired, done
  );

endinterface

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD digit of the down-counter: load with clamp to 9, or decrement with borrow.
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               borrow_i,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_digit_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               borrow_o
);

  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (load_i) begin
      digit_o = (load_digit_i > DIGIT_W'(9)) ? DIGIT_W'(9) : load_digit_i;
    end else if (borrow_i) begin
      if (digit_i == '0) begin
        digit_o  = DIGIT_W'(9);
        borrow_o = 1'b1;
      end else begin
        digit_o = digit_i - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// SS.hh BCD countdown timer decrementing at TICK_HZ; states: IDLE loaded/idle,
// RUN counting, PAUSED held mid-count, EXPIRED reached 00.00.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  bcd_countdown_timer_if.slave bus
);

  localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PW  = presc_width(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_e                state_q, state_d;
  logic [4*DIGIT_W-1:0]  count_q, count_d, count_nxt;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  done_q, done_d;
  logic                  tick, dec;
  logic [4:0]            borrow;

  assign tick      = (state_q == RUN) && (presc_q == PRESC_LAST);
  // load and start_stop both outrank a tick, so the chain only borrows when neither is present
  assign dec       = tick && !bus.load && !bus.start_stop;
  assign borrow[0] = dec;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_down_digit u_digit (
      .digit_i      (count_q[i*DIGIT_W +: DIGIT_W]),
      .borrow_i     (borrow[i]),
      .load_i       (bus.load),
      .load_digit_i (bus.load_value[i*DIGIT_W +: DIGIT_W]),
      .digit_o      (count_nxt[i*DIGIT_W +: DIGIT_W]),
      .borrow_o     (borrow[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    if (bus.load) begin
      state_d = IDLE;
      count_d = count_nxt;
      presc_d = '0;
    end else if (bus.start_stop) begin
      case (state_q)
        IDLE, PAUSED: begin
          if (count_q != '0) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          state_d = PAUSED;
          presc_d = '0;
        end
        default: ;
      endcase
    end else if (state_q == RUN) begin
      if (tick) begin
        presc_d = '0;
        // a borrow out of the tens digit would be an underflow; pin at zero instead
        if (count_nxt == '0 || borrow[4]) begin
          count_d = '0;
          state_d = EXPIRED;
          done_d  = 1'b1;
        end else begin
          count_d = count_nxt;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign bus.count_bcd = count_q;
  assign bus.running   = (state_q == RUN);
  assign bus.expired   = (state_q == EXPIRED);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed and random stimulus for bcd_countdown_timer against a centisecond-count model.
module tb_bcd_countdown_timer;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bcd_countdown_timer_if bus();

  bcd_countdown_timer #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: remaining time in hundredths of a second, state 0 idle 1 run 2 paused 3 expired
  int m_cnt = 0;
  int m_st  = 0;
  int m_pre = 0;
  bit m_done = 1'b0;

  function automatic int clamp_val(logic [15:0] v);
    int total;
    logic [3:0] n;
    total = 0;
    for (int i = 3; i >= 0; i--) begin
      n = v[i*4 +: 4];
      total = total * 10 + ((n > 4'd9) ? 9 : int'(n));
    end
    return total;
  endfunction

  function automatic logic [15:0] to_bcd(int c);
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(bit r, bit ld, logic [15:0] v, bit ss);
    if (r) begin
      m_cnt = 0; m_st = 0; m_pre = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (ld) begin
        m_cnt = clamp_val(v); m_st = 0; m_pre = 0;
      end else if (ss) begin
        if ((m_st == 0 || m_st == 2) && m_cnt != 0) begin
          m_st = 1; m_pre = 0;
        end else if (m_st == 1) begin
          m_st = 2; m_pre = 0;
        end
      end else if (m_st == 1) begin
        if (m_pre == DIV - 1) begin
          m_pre = 0;
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_st = 3; m_done = 1'b1;
          end
        end else begin
          m_pre++;
        end
      end
    end
  endtask

  task automatic step(bit r, bit ld, logic [15:0] v, bit ss);
    rst = r; bus.load = ld; bus.load_value = v; bus.start_stop = ss;
    @(posedge clk);
    model_edge(r, ld, v, ss);
    #1;
    rst = 1'b0; bus.load = 1'b0; bus.start_stop = 1'b0;
    chk("model_count",   bus.count_bcd,       to_bcd(m_cnt));
    chk("model_running", 16'(bus.running),    16'(m_st == 1));
    chk("model_expired", 16'(bus.expired),    16'(m_st == 3));
    chk("model_done",    16'(bus.done),       16'(m_done));
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    bit r, ld, ss;
    logic [15:0] v;
    bus.load = 1'b0; bus.load_value = 16'h0000; bus.start_stop = 1'b0;

    step(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("reset_count", bus.count_bcd, 16'h0000);
    chk("reset_flags", {13'b0, bus.running, bus.expired, bus.done}, 16'h0000);

    // borrow across digits
    step(1'b0, 1'b1, 16'h0102, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("start_running", 16'(bus.running), 16'h0001);
    idle(10); chk("dec_0101", bus.count_bcd, 16'h0101);
    idle(10); chk("dec_0100", bus.count_bcd, 16'h0100);
    idle(10); chk("dec_0099", bus.count_bcd, 16'h0099);
    idle(10); chk("dec_0098", bus.count_bcd, 16'h0098);

    // expiry and one-cycle done
    step(1'b0, 1'b1, 16'h0003, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    idle(10); chk("exp_0002", bus.count_bcd, 16'h0002);
    idle(10); chk("exp_0001", bus.count_bcd, 16'h0001);
    idle(9);  chk("exp_pre_done", 16'(bus.done), 16'h0000);
    idle(1);
    chk("exp_0000", bus.count_bcd, 16'h0000);
    chk("exp_done_hi", {13'b0, bus.running, bus.expired, bus.done}, 16'h0003);
    idle(1);
    chk("exp_done_lo", {13'b0, bus.running, bus.expired, bus.done}, 16'h0002);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("exp_ss_ignored", {13'b0, bus.running, bus.expired, bus.done}, 16'h0002);

    // pause / resume
    step(1'b0, 1'b1, 16'h0050, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    idle(15);
    chk("pause_0049", bus.count_bcd, 16'h0049);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("paused_not_running", 16'(bus.running), 16'h0000);
    idle(100);
    chk("paused_hold", bus.count_bcd, 16'h0049);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    idle(9);
    chk("resume_full_div", bus.count_bcd, 16'h0049);
    idle(1);
    chk("resume_0048", bus.count_bcd, 16'h0048);

    // zero load cannot start
    step(1'b0, 1'b1, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("zero_no_run", 16'(bus.running), 16'h0000);
    idle(20);
    chk("zero_no_done", {13'b0, bus.running, bus.expired, bus.done}, 16'h0000);

    // clamp
    step(1'b0, 1'b1, 16'hAF9C, 1'b0);
    chk("clamp_9999", bus.count_bcd, 16'h9999);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    idle(10);
    chk("clamp_9998", bus.count_bcd, 16'h9998);

    // load beats start_stop while running
    step(1'b0, 1'b1, 16'h0042, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    idle(4);
    step(1'b0, 1'b1, 16'h1000, 1'b1);
    chk("load_prio_count", bus.count_bcd, 16'h1000);
    chk("load_prio_idle", 16'(bus.running), 16'h0000);

    // reset mid-run, including on the cycle that would have expired
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    idle(5);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("rst_run_count", bus.count_bcd, 16'h0000);
    chk("rst_run_flags", {13'b0, bus.running, bus.expired, bus.done}, 16'h0000);
    step(1'b0, 1'b1, 16'h0001, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    idle(9);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("rst_tick_no_done", {13'b0, bus.running, bus.expired, bus.done}, 16'h0000);
    idle(1);
    chk("rst_tick_after", 16'(bus.done), 16'h0000);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 149) == 0);
      ss = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) v = 16'($urandom);
      else                           v = 16'($urandom_range(0, 18));
      step(r, ld, v, ss);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
